imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning instruction-memory size in 32-bit words.
REQ-002 SHALL have parameter AW, default 6, meaning word-address width (log2 DEPTH).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port start  input  1  load request, sampled in IDLE and DONE only.
REQ-006 SHALL have port len  input  7  word count to load, captured when start is accepted.
REQ-007 SHALL have port s_valid  input  1  byte-stream data valid.
REQ-008 SHALL have port s_data  input  8  byte-stream payload.
REQ-009 SHALL have port s_ready  output  1  byte-stream ready; a byte transfers on s_valid & s_ready at a rising edge.
REQ-010 SHALL have port we  output  1  instruction-memory write enable, one-cycle pulse per word.
REQ-011 SHALL have port wa  output  AW  instruction-memory word address.
REQ-012 SHALL have port wd  output  32  instruction-memory write data.
REQ-013 SHALL have port cpu_reset  output  1  active-high hold-in-reset for the processor.
REQ-014 SHALL have ports busy and done  output  1 each  load in progress / load complete.

Function
REQ-015 SHALL implement states IDLE, LOAD, WRLAST, DONE; all outputs registered or decoded from state only.
REQ-016 In IDLE or DONE, start=1 SHALL capture len (clamped to DEPTH if len > DEPTH), clear word counter and byte counter, and go to LOAD; len=0 SHALL go directly to DONE with no write.
REQ-017 start SHALL be ignored in LOAD and WRLAST.
REQ-018 s_ready SHALL be 1 exactly in LOAD; 0 in IDLE, WRLAST, DONE.
REQ-019 Bytes SHALL be assembled big-endian: 1st accepted byte -> bits 31:24, 4th -> bits 7:0.
REQ-020 On acceptance of a word's 4th byte, we SHALL be 1 in the following cycle with wd = assembled word and wa = word index (0 for first word, +1 per word, no gaps).
REQ-021 If that word is not the last, state SHALL remain LOAD and s_ready stays 1 during the write cycle (back-to-back streaming, 4 cycles/word minimum).
REQ-022 If that word is the last (index = captured len-1), state SHALL go to WRLAST for exactly one cycle carrying the we pulse, then DONE.
REQ-023 Cycles with s_valid=0 SHALL not advance byte or word counters and SHALL not pulse we.
REQ-024 we SHALL be 0 in every cycle except the one following a 4th-byte acceptance; wa/wd SHALL hold their last value otherwise.
REQ-025 cpu_reset SHALL be 1 in IDLE, LOAD, WRLAST and 0 only in DONE, so release occurs the cycle after the final write.
REQ-026 busy SHALL be 1 in LOAD and WRLAST; done SHALL be 1 only in DONE.
REQ-027 start in DONE SHALL re-enter LOAD (or stay DONE if len=0) with cpu_reset returning to 1 in the next cycle.
REQ-028 Word counter SHALL never exceed DEPTH-1; with clamped len=DEPTH the last write SHALL be wa=DEPTH-1 and no wrap to 0 occurs.

Reset
REQ-029 reset=0 SHALL immediately (asynchronously) force IDLE, s_ready=0, we=0, wa=0, wd=0, cpu_reset=1, busy=0, done=0, counters=0.
REQ-030 reset during LOAD SHALL discard any partially assembled word; memory words already written are not touched; no we pulse follows reset release.

Verification
REQ-031 Reset, start len=1, bytes 20,02,00,05 back-to-back -> single we with wa=0, wd=32'h20020005; WRLAST one cycle; cpu_reset falls and done rises next cycle.
REQ-032 len=3, 12 bytes with random s_valid gaps -> exactly three we pulses at wa=0,1,2 with correct big-endian wd; no we on idle cycles.
REQ-033 len=0 -> DONE the cycle after start, zero we pulses, s_ready never 1.
REQ-034 len=100 with continuous stream -> exactly 64 we pulses, wa 0..63, s_ready=0 after 256th byte, done=1.
REQ-035 reset driven low after 6 bytes of len=2 load -> all outputs at reset values immediately; after release, start len=1 with 4 bytes writes wa=0 with the new word only.
REQ-036 start pulsed mid-LOAD -> ignored, load completes as captured; start pulsed in DONE -> cpu_reset=1 next cycle, reload from wa=0.

Source files
------------

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream valid/ready channel feeding the instruction loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Assembles a big-endian byte stream into 32-bit words, writes
//               them to instruction memory and holds the CPU in reset until done.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          start,
  input  wire logic [6:0]    len,
  imem_loader_if.slave       s,
  output logic               we,
  output logic [AW-1:0]      wa,
  output logic [31:0]        wd,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_WRLAST = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [6:0]    c_depth_len = 7'(DEPTH);
  localparam logic [AW-1:0] c_wcnt_one  = {{(AW-1){1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_next;
  logic [6:0]    r_len;
  logic [AW-1:0] r_wcnt;
  logic [1:0]    r_bcnt;
  logic [23:0]   r_shift;

  logic [6:0]    w_len_clamp;
  logic          w_accept_start;
  logic          w_xfer;
  logic          w_last_byte;
  logic          w_last_word;

  assign w_len_clamp    = (len > c_depth_len) ? c_depth_len : len;
  assign w_accept_start = start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_xfer         = s.s_valid & (r_state == S_LOAD);
  assign w_last_byte    = w_xfer & (r_bcnt == 2'd3);
  // The counter stops on the last word, so it never wraps past DEPTH-1.
  assign w_last_word    = (7'(r_wcnt) == (r_len - 7'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next = (w_len_clamp == 7'd0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_last_byte && w_last_word) begin
          w_next = S_WRLAST;
        end
      end
      S_WRLAST: w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len   <= 7'd0;
      r_wcnt  <= '0;
      r_bcnt  <= 2'd0;
      r_shift <= 24'd0;
      we      <= 1'b0;
      wa      <= '0;
      wd      <= 32'd0;
    end else begin
      we <= 1'b0;
      if (w_accept_start) begin
        r_len  <= w_len_clamp;
        r_wcnt <= '0;
        r_bcnt <= 2'd0;
      end else if (w_xfer) begin
        r_bcnt <= r_bcnt + 2'd1;
        if (r_bcnt == 2'd3) begin
          we <= 1'b1;
          wa <= r_wcnt;
          wd <= {r_shift, s.s_data};
          if (!w_last_word) begin
            r_wcnt <= r_wcnt + c_wcnt_one;
          end
        end else begin
          r_shift <= {r_shift[15:0], s.s_data};
        end
      end
    end
  end

  assign s.s_ready = (r_state == S_LOAD);
  assign busy      = (r_state == S_LOAD) | (r_state == S_WRLAST);
  assign done      = (r_state == S_DONE);
  assign cpu_reset = (r_state != S_DONE);

endmodule
`default_nettype wire
